// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the 0-59 s countdown timer controller.
//   SEC_W            width of the seconds value
//   ST_IDLE..ST_DONE 2-bit run-state encodings
//   sec_wrap_inc/dec wrap-around edit helpers used by the IDLE/PAUSE editor
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package countdown_pkg;

   localparam int SEC_W = 6;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Increment that wraps from the configured maximum back to zero
   function automatic logic [SEC_W-1:0] sec_wrap_inc(input logic [SEC_W-1:0] sec,
                                                     input logic [SEC_W-1:0] max_sec);
      return (sec >= max_sec) ? '0 : sec + 1'b1;
   endfunction

   // Decrement that wraps from zero up to the configured maximum
   function automatic logic [SEC_W-1:0] sec_wrap_dec(input logic [SEC_W-1:0] sec,
                                                     input logic [SEC_W-1:0] max_sec);
      return (sec == '0) ? max_sec : sec - 1'b1;
   endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// ---------------------------------------------------------------------------
// countdown_ctrl_if
// Key-pulse / display bundle between the debouncer, the controller and the
// BCD/display path.
//   start_pause_p, reset_p, add_p, sub_p : 1-cycle key pulses (master -> slave)
//   seconds[SEC_W-1:0], running, done,
//   disp_en                             : registered status (slave -> master)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface countdown_ctrl_if;
   import countdown_pkg::*;

   logic             start_pause_p;
   logic             reset_p;
   logic             add_p;
   logic             sub_p;
   logic [SEC_W-1:0] seconds;
   logic             running;
   logic             done;
   logic             disp_en;

   modport master (
      output start_pause_p, reset_p, add_p, sub_p,
      input  seconds, running, done, disp_en
   );

   modport slave (
      input  start_pause_p, reset_p, add_p, sub_p,
      output seconds, running, done, disp_en
   );

endinterface

// File: rtl/countdown_tick_gen.sv
// ---------------------------------------------------------------------------
// countdown_tick_gen
// Free-running 1 s prescaler for the countdown controller.
//   clk, rst_n   system clock, asynchronous active-low reset
//   clear_i      forces the count to zero (wins over enable_i)
//   enable_i     advances the count, wrapping at CLK_HZ-1
//   half_tick_o  count at CLK_HZ/2-1 while enabled (only with
//                COUNTDOWN_DONE_BLINK_EN defined)
//   tick_o       count at CLK_HZ-1 while enabled
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module countdown_tick_gen #(
   parameter int CLK_HZ = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
`ifdef COUNTDOWN_DONE_BLINK_EN
   output logic half_tick_o,
`endif
   output logic tick_o
);

   localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] count_q;
   logic [PW-1:0] count_d;

   // Next count: clear dominates, otherwise count while enabled and wrap
   // at the end of the second so the fraction restarts cleanly.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   // Prescaler register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = enable_i && (count_q == LAST);

`ifdef COUNTDOWN_DONE_BLINK_EN
   localparam logic [PW-1:0] HALF_LAST = PW'(CLK_HZ / 2 - 1);

   assign half_tick_o = enable_i && (count_q == HALF_LAST);
`endif

endmodule

// File: rtl/countdown_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_ctrl
// Run-state sequencer for the 0..MAX_SEC countdown timer.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ctrl_if  slave side of countdown_ctrl_if: key pulses in, registered
//            seconds / running / done / disp_en out
// Optional feature: define COUNTDOWN_DONE_BLINK_EN to blink disp_en every
// CLK_HZ/2 clocks while in DONE; otherwise disp_en is tied high.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int CLK_HZ      = 10_000_000,
   parameter int MAX_SEC     = 59,
   parameter int DEFAULT_SEC = 30
) (
   input  logic           clk,
   input  logic           rst_n,
   countdown_ctrl_if.slave ctrl_if
);

   localparam logic [SEC_W-1:0] MAX_S = SEC_W'(MAX_SEC);
   localparam logic [SEC_W-1:0] DEF_S = SEC_W'(DEFAULT_SEC);
   localparam logic [SEC_W-1:0] ONE_S = SEC_W'(1);

   logic             start_p;
   logic             reset_p;
   logic             add_p;
   logic             sub_p;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [SEC_W-1:0] seconds_q;
   logic [SEC_W-1:0] seconds_d;
   logic             running_q;
   logic             done_q;

   logic             tick;
   logic             presc_clear;
   logic             presc_enable;

   assign start_p = ctrl_if.start_pause_p;
   assign reset_p = ctrl_if.reset_p;
   assign add_p   = ctrl_if.add_p;
   assign sub_p   = ctrl_if.sub_p;

`ifdef COUNTDOWN_DONE_BLINK_EN
   logic half_tick;
   logic disp_en_q;
   logic disp_en_d;
`endif

   // Prescaler control. The fraction of a second survives a pause, so the
   // counter is only cleared when leaving the run/pause pair (reset key, ack
   // of DONE) and while idle. With blinking it also runs in DONE; the wrap on
   // the final tick leaves it at zero on DONE entry.
   always_comb begin
      presc_clear  = (state_q == ST_IDLE) || reset_p || ((state_q == ST_DONE) && start_p);
      presc_enable = (state_q == ST_RUN);
`ifdef COUNTDOWN_DONE_BLINK_EN
      presc_enable = presc_enable || (state_q == ST_DONE);
`else
      presc_clear  = presc_clear || (state_q == ST_DONE);
`endif
   end

   countdown_tick_gen #(
      .CLK_HZ      (CLK_HZ)
   ) u_tick_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (presc_clear),
      .enable_i    (presc_enable),
`ifdef COUNTDOWN_DONE_BLINK_EN
      .half_tick_o (half_tick),
`endif
      .tick_o      (tick)
   );

   // Run state machine and seconds register. Key priority is reset > start/
   // pause > add > sub; a lower key in the same cycle as a higher one is
   // dropped. In RUN a tick is applied before a pause request, so the final
   // tick reaching zero goes to DONE even if pause was pressed that cycle.
   always_comb begin
      state_d   = state_q;
      seconds_d = seconds_q;
      case (state_q)
         ST_IDLE: begin
            if (reset_p) begin
               seconds_d = DEF_S;
            end else if (start_p) begin
               if (seconds_q != '0) begin
                  state_d = ST_RUN;
               end
            end else if (add_p) begin
               seconds_d = sec_wrap_inc(seconds_q, MAX_S);
            end else if (sub_p) begin
               seconds_d = sec_wrap_dec(seconds_q, MAX_S);
            end
         end
         ST_RUN: begin
            if (reset_p) begin
               state_d   = ST_IDLE;
               seconds_d = DEF_S;
            end else if (tick && (seconds_q == ONE_S)) begin
               state_d   = ST_DONE;
               seconds_d = '0;
            end else begin
               if (tick) begin
                  seconds_d = seconds_q - 1'b1;
               end
               if (start_p) begin
                  state_d = ST_PAUSE;
               end
            end
         end
         ST_PAUSE: begin
            if (reset_p) begin
               state_d   = ST_IDLE;
               seconds_d = DEF_S;
            end else if (start_p) begin
               if (seconds_q != '0) begin
                  state_d = ST_RUN;
               end
            end else if (add_p) begin
               seconds_d = sec_wrap_inc(seconds_q, MAX_S);
            end else if (sub_p) begin
               seconds_d = sec_wrap_dec(seconds_q, MAX_S);
            end
         end
         ST_DONE: begin
            seconds_d = '0;
            if (reset_p || start_p) begin
               state_d   = ST_IDLE;
               seconds_d = DEF_S;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            seconds_d = DEF_S;
         end
      endcase
   end

   // State, seconds and status flags. running/done are decoded from the
   // next state so they change on the same edge as the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         seconds_q <= DEF_S;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         seconds_q <= seconds_d;
         running_q <= (state_d == ST_RUN);
         done_q    <= (state_d == ST_DONE);
      end
   end

`ifdef COUNTDOWN_DONE_BLINK_EN
   // Blink mask: high outside DONE and on the DONE entry edge, then inverted
   // on every half second (half_tick and tick both fire inside one second).
   always_comb begin
      disp_en_d = disp_en_q;
      if ((state_d != ST_DONE) || (state_q != ST_DONE)) begin
         disp_en_d = 1'b1;
      end else if (half_tick || tick) begin
         disp_en_d = ~disp_en_q;
      end
   end

   // Blink mask register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_en_q <= 1'b1;
      end else begin
         disp_en_q <= disp_en_d;
      end
   end

   assign ctrl_if.disp_en = disp_en_q;
`else
   assign ctrl_if.disp_en = 1'b1;
`endif

   assign ctrl_if.seconds = seconds_q;
   assign ctrl_if.running = running_q;
   assign ctrl_if.done    = done_q;

endmodule
